ase_local_mem_axi_bank: RTL and testbench

ASE_LOCAL_MEM_AXI_BANK -- requirements
Module: ase_local_mem_axi_bank

---
 rtl/ase_local_mem_pkg.sv | 18 +
 rtl/ase_local_mem_ram.sv | 40 ++++
 rtl/ase_local_mem_axi_bank.sv | 225 ++++++++++++++++++++++
 tb/tb_ase_local_mem_axi_bank.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ase_local_mem_pkg.sv
// Shared definitions for the local-memory AXI bank: response codes and FSM state encodings.
package ase_local_mem_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/ase_local_mem_ram.sv
// Single-clock line memory: byte-enabled write port and a registered read-first read port.
module ase_local_mem_ram #(
    parameter int LINES      = 4096,
    parameter int DATA_WIDTH = 512,
    parameter int LINE_BITS  = $clog2(LINES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [LINE_BITS-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    re,
    input  logic [LINE_BITS-1:0]    raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [LINES];

    // The array itself has no reset: contents survive reset_n by design.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_WIDTH/8; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Non-blocking read of the same cycle's write target returns the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ase_local_mem_axi_bank.sv
// AXI slave front end for one local memory bank: independent write (AW/W/B) and read (AR/R) FSMs.
// Handshake rule on every channel: a transfer happens on a rising clk edge where valid && ready.
module ase_local_mem_axi_bank
    import ase_local_mem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 27,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 8,
    parameter int USER_WIDTH      = 8,
    parameter int RID_WIDTH       = 9,
    parameter int WID_WIDTH       = 9,
    parameter int MEM_LINES       = 4096
) (
    input  logic                                         clk,
    input  logic                                         reset_n,

    input  logic                                         awvalid,
    output logic                                         awready,
    input  logic [WID_WIDTH-1:0]                         awid,
    input  logic [ADDR_WIDTH+$clog2(DATA_WIDTH/8)-1:0]   awaddr,
    input  logic [BURST_CNT_WIDTH-1:0]                   awlen,
    input  logic [2:0]                                   awsize,
    input  logic [1:0]                                   awburst,
    input  logic [USER_WIDTH-1:0]                        awuser,

    input  logic                                         wvalid,
    output logic                                         wready,
    input  logic [DATA_WIDTH-1:0]                        wdata,
    input  logic [DATA_WIDTH/8-1:0]                      wstrb,
    input  logic                                         wlast,
    input  logic [USER_WIDTH-1:0]                        wuser,

    output logic                                         bvalid,
    input  logic                                         bready,
    output logic [WID_WIDTH-1:0]                         bid,
    output logic [1:0]                                   bresp,
    output logic [USER_WIDTH-1:0]                        buser,

    input  logic                                         arvalid,
    output logic                                         arready,
    input  logic [RID_WIDTH-1:0]                         arid,
    input  logic [ADDR_WIDTH+$clog2(DATA_WIDTH/8)-1:0]   araddr,
    input  logic [BURST_CNT_WIDTH-1:0]                   arlen,
    input  logic [2:0]                                   arsize,
    input  logic [1:0]                                   arburst,
    input  logic [USER_WIDTH-1:0]                        aruser,

    output logic                                         rvalid,
    input  logic                                         rready,
    output logic [RID_WIDTH-1:0]                         rid,
    output logic [DATA_WIDTH-1:0]                        rdata,
    output logic [1:0]                                   rresp,
    output logic                                         rlast,
    output logic [USER_WIDTH-1:0]                        ruser,

    output wr_state_t                                    wr_state,
    output rd_state_t                                    rd_state
);

    localparam int OFF_BITS  = $clog2(DATA_WIDTH/8);
    localparam int LINE_BITS = $clog2(MEM_LINES);

    wr_state_t w_next;
    rd_state_t r_next;

    // Held low through reset and for the first edge after release so no address is accepted early.
    logic live;

    logic [WID_WIDTH-1:0]       w_id;
    logic [USER_WIDTH-1:0]      w_user;
    logic [BURST_CNT_WIDTH-1:0] w_len;
    logic [BURST_CNT_WIDTH-1:0] w_beat;
    logic [LINE_BITS-1:0]       w_line;
    logic                       w_ok;
    logic [1:0]                 b_resp;

    logic [RID_WIDTH-1:0]       r_id;
    logic [USER_WIDTH-1:0]      r_user;
    logic [BURST_CNT_WIDTH-1:0] r_len;
    logic [BURST_CNT_WIDTH-1:0] r_beat;
    logic [LINE_BITS-1:0]       r_line;

    logic aw_hs, w_hs, ar_hs, r_hs, w_final, r_final;
    logic [LINE_BITS-1:0] aw_line, ar_line;
    logic                 ram_re;
    logic [LINE_BITS-1:0] ram_raddr;

    // Size, burst type, offset bits and wuser carry no meaning for this bank.
    logic unused_ok;
    assign unused_ok = ^{awsize, awburst, arsize, arburst, wuser, awaddr, araddr};

    assign aw_line = awaddr[OFF_BITS +: LINE_BITS];
    assign ar_line = araddr[OFF_BITS +: LINE_BITS];

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;
    assign w_final = (w_beat == w_len);
    assign r_final = (r_beat == r_len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= w_next;
            rd_state <= r_next;
        end
    end

    always_comb begin
        w_next  = wr_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                awready = live;
                if (awvalid && live) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_final) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next  = rd_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        case (rd_state)
            R_IDLE: begin
                arready = live;
                if (arvalid && live) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = r_final;
                if (rready && r_final) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live   <= 1'b0;
            w_id   <= '0;
            w_user <= '0;
            w_len  <= '0;
            w_beat <= '0;
            w_line <= '0;
            w_ok   <= 1'b0;
            b_resp <= OKAY;
            r_id   <= '0;
            r_user <= '0;
            r_len  <= '0;
            r_beat <= '0;
            r_line <= '0;
        end else begin
            live <= 1'b1;
            if (aw_hs) begin
                w_id   <= awid;
                w_user <= awuser;
                w_len  <= awlen;
                w_beat <= '0;
                w_line <= aw_line;
                w_ok   <= 1'b1;
            end
            if (w_hs) begin
                w_line <= w_line + LINE_BITS'(1);
                w_beat <= w_beat + BURST_CNT_WIDTH'(1);
                w_ok   <= w_ok && (wlast == w_final);
                // OKAY only if wlast was absent on every earlier beat and present on this one.
                if (w_final) b_resp <= (w_ok && wlast) ? OKAY : SLVERR;
            end
            if (ar_hs) begin
                r_id   <= arid;
                r_user <= aruser;
                r_len  <= arlen;
                r_beat <= '0;
                r_line <= ar_line + LINE_BITS'(1);
            end else if (r_hs && !r_final) begin
                r_line <= r_line + LINE_BITS'(1);
                r_beat <= r_beat + BURST_CNT_WIDTH'(1);
            end
        end
    end

    // The RAM output register is rdata; it only reloads on AR accept or a non-final R transfer.
    assign ram_re    = ar_hs || (r_hs && !r_final);
    assign ram_raddr = ar_hs ? ar_line : r_line;

    ase_local_mem_ram #(
        .LINES      (MEM_LINES),
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_BITS  (LINE_BITS)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset_n),
        .we    (w_hs),
        .waddr (w_line),
        .wdata (wdata),
        .wstrb (wstrb),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (rdata)
    );

    assign bid   = w_id;
    assign buser = w_user;
    assign bresp = b_resp;
    assign rid   = r_id;
    assign ruser = r_user;
    assign rresp = OKAY;

endmodule

// File: tb/tb_ase_local_mem_axi_bank.sv
// Directed bench for ase_local_mem_axi_bank: drivers push expected B/R responses, monitors pop and compare.
module tb_ase_local_mem_axi_bank;
    import ase_local_mem_pkg::*;

    localparam int DW    = 512;
    localparam int SW    = DW/8;
    localparam int LINES = 4096;

    logic          clk;
    logic          reset_n;
    logic          awvalid, awready;
    logic [8:0]    awid;
    logic [32:0]   awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic [7:0]    awuser;
    logic          wvalid, wready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast;
    logic [7:0]    wuser;
    logic          bvalid, bready;
    logic [8:0]    bid;
    logic [1:0]    bresp;
    logic [7:0]    buser;
    logic          arvalid, arready;
    logic [8:0]    arid;
    logic [32:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [7:0]    aruser;
    logic          rvalid, rready;
    logic [8:0]    rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic [7:0]    ruser;
    wr_state_t     wr_state;
    rd_state_t     rd_state;

    ase_local_mem_axi_bank dut (
        .clk(clk), .reset_n(reset_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awuser(awuser),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp), .buser(buser),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .aruser(aruser),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .ruser(ruser), .wr_state(wr_state), .rd_state(rd_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct { logic [8:0] id; logic [1:0] resp; logic [7:0] user; } b_exp_t;
    typedef struct { logic [8:0] id; logic [DW-1:0] data; logic last; logic [7:0] user; } r_exp_t;
    b_exp_t b_q[$];
    r_exp_t r_q[$];

    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] wd [16];
    logic [SW-1:0] ws [16];
    logic          wl [16];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_get(input int line);
        return ref_mem.exists(line) ? ref_mem[line] : '0;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (reset_n && bvalid && bready) begin
            if (b_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected bid=%0h bresp=%0h", bid, bresp);
            end else begin
                b_exp_t e;
                e = b_q.pop_front();
                chk("bid", DW'(bid), DW'(e.id));
                chk("bresp", DW'(bresp), DW'(e.resp));
                chk("buser", DW'(buser), DW'(e.user));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && rvalid && rready) begin
            if (r_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL r_unexpected rid=%0h rdata=%0h", rid, rdata);
            end else begin
                r_exp_t e;
                e = r_q.pop_front();
                chk("rdata", rdata, e.data);
                chk("rlast", DW'(rlast), DW'(e.last));
                chk("rid", DW'(rid), DW'(e.id));
                chk("ruser", DW'(ruser), DW'(e.user));
                chk("rresp", DW'(rresp), DW'(2'b00));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, DW'({awready, arready, wready, bvalid, rvalid, rlast}), '0);
        chk({tag, "_side"}, DW'({bid, bresp, buser, rid, rresp, ruser}), '0);
        chk({tag, "_rdata"}, rdata, '0);
    endtask

    // abort_after > 0 pulses reset right after that many beats have been accepted.
    task automatic do_write(input logic [8:0] id, input int line, input int off, input int len,
                            input logic [1:0] exp_resp, input int abort_after);
        int n;
        @(posedge clk); #1;
        awvalid = 1'b1; awid = id; awaddr = (33'(line) << 6) | 33'(off);
        awlen = 8'(len); awsize = 3'd6; awburst = 2'b01; awuser = 8'(id) ^ 8'h3C;
        n = 0;
        @(negedge clk);
        while (!awready && n < 100) begin @(negedge clk); n++; end
        chk("aw_wait_timeout", DW'(n >= 100), '0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wlast = wl[b]; wuser = 8'(b);
            n = 0;
            @(negedge clk);
            while (!wready && n < 100) begin @(negedge clk); n++; end
            chk("w_wait_timeout", DW'(n >= 100), '0);
            @(posedge clk);
            begin
                logic [DW-1:0] cur;
                cur = ref_get((line + b) % LINES);
                for (int k = 0; k < SW; k++) if (wd[b] !== 'x && ws[b][k]) cur[k*8 +: 8] = wd[b][k*8 +: 8];
                ref_mem[(line + b) % LINES] = cur;
            end
            #1;
            if (abort_after > 0 && b + 1 == abort_after) begin
                wvalid = 1'b0;
                reset_n = 1'b0;
                #1;
                check_reset_outputs("midreset");
                repeat (2) @(posedge clk);
                @(negedge clk);
                reset_n = 1'b1;
                @(posedge clk); #1;
                chk("ready_after_midreset", DW'({awready, arready, bvalid}), DW'(3'b110));
                repeat (4) @(posedge clk);
                #1;
                chk("no_b_after_abort", DW'(bvalid), '0);
                return;
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        b_q.push_back('{id: id, resp: exp_resp, user: 8'(id) ^ 8'h3C});
        chk("bvalid_next_cycle", DW'(bvalid), DW'(1'b1));
        n = 0;
        while (b_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("b_drain_timeout", DW'(n >= 100), '0);
    endtask

    task automatic do_read(input logic [8:0] id, input int line, input int len, input int stall);
        int n;
        for (int i = 0; i <= len; i++) begin
            r_q.push_back('{id: id, data: ref_get((line + i) % LINES), last: (i == len), user: 8'(id) ^ 8'h5A});
        end
        @(posedge clk); #1;
        rready = (stall == 0);
        arvalid = 1'b1; arid = id; araddr = (33'(line) << 6) | 33'(line % 64);
        arlen = 8'(len); arsize = 3'd6; arburst = 2'b01; aruser = 8'(id) ^ 8'h5A;
        n = 0;
        @(negedge clk);
        while (!arready && n < 100) begin @(negedge clk); n++; end
        chk("ar_wait_timeout", DW'(n >= 100), '0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("rvalid_one_cycle", DW'(rvalid), DW'(1'b1));
        if (stall > 0) begin
            repeat (stall) begin
                @(negedge clk);
                chk("stall_rvalid", DW'(rvalid), DW'(1'b1));
                chk("stall_rdata", rdata, r_q[0].data);
                chk("stall_rlast", DW'(rlast), DW'(r_q[0].last));
            end
            @(posedge clk); #1;
            rready = 1'b1;
        end
        n = 0;
        while (r_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        chk("r_drain_timeout", DW'(n >= 500), '0);
        @(posedge clk); #1;
        chk("rvalid_drops", DW'(rvalid), '0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awuser = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; wuser = 0; bready = 1'b1;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; aruser = 0;
        rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", DW'({awready, arready}), DW'(2'b11));

        // single-beat write at byte 0x40, A5 pattern
        wd[0] = {64{8'hA5}}; ws[0] = '1; wl[0] = 1'b1;
        do_write(9'h005, 1, 0, 0, 2'b00, 0);
        do_read(9'h003, 1, 0, 0);

        // 4-beat burst at line 10 with data 1..4; offset bits in awaddr must be ignored
        for (int i = 0; i < 4; i++) begin wd[i] = DW'(i + 1); ws[i] = '1; wl[i] = (i == 3); end
        do_write(9'h011, 10, 37, 3, 2'b00, 0);
        do_read(9'h1A7, 10, 3, 0);

        // partial strobe on an untouched line
        wd[0] = '1; ws[0] = SW'(1); wl[0] = 1'b1;
        do_write(9'h020, 100, 0, 0, 2'b00, 0);
        do_read(9'h021, 100, 0, 0);
        chk("partial_strobe_model", ref_get(100), DW'(8'hFF));

        // wrap from the last line to line 0
        wd[0] = {64{8'h11}}; wd[1] = {64{8'h22}}; ws[0] = '1; ws[1] = '1; wl[0] = 0; wl[1] = 1;
        do_write(9'h030, LINES - 1, 0, 1, 2'b00, 0);
        do_read(9'h031, LINES - 1, 1, 0);
        do_read(9'h032, 0, 0, 0);

        // stalled read: first beat of line 10 held for 5 cycles
        do_read(9'h040, 10, 3, 5);

        // early wlast on beat 1 of 2 -> SLVERR
        wd[0] = DW'(64'hDEAD); wd[1] = DW'(64'hBEEF); ws[0] = '1; ws[1] = '1; wl[0] = 1; wl[1] = 0;
        do_write(9'h050, 200, 0, 1, 2'b10, 0);
        // missing wlast on a single beat -> SLVERR
        wd[0] = DW'(64'h1234); ws[0] = '1; wl[0] = 0;
        do_write(9'h051, 300, 0, 0, 2'b10, 0);
        do_read(9'h052, 200, 1, 0);

        // reset after beat 2 of 4 at line 20; written beats survive
        for (int i = 0; i < 4; i++) begin wd[i] = DW'(64'hC0DE_0000 + i); ws[i] = '1; wl[i] = (i == 3); end
        do_write(9'h060, 20, 0, 3, 2'b00, 2);
        do_read(9'h061, 20, 3, 0);
        chk("abort_beat3_unwritten", ref_get(22), '0);

        repeat (5) @(posedge clk);
        chk("queues_empty", DW'(b_q.size() + r_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
